// File: rtl/xpb_accum_ctrl_if.sv
// -----------------------------------------------------------------------------
// xpb_accum_ctrl_if
//
// Bundles the operand handshake, the xpb table lookup bus and the result
// handshake of xpb_accum_ctrl.
//
// Parameters:
//   NUM_DIGITS  number of 5-bit digits per operand (2..64)
//   DATA_W      xpb table entry width
//
// Signals:
//   in_valid / in_ready / in_digits   operand handshake, digit i = [5i+4:5i]
//   xpb_req / xpb_sel / xpb_digit     table lookup issued by the controller
//   xpb_data                          registered table output (cycle after req)
//   out_valid / out_ready / out_sum   result handshake
//   busy                              controller is not idle
//
// Modports:
//   slave   the controller side (xpb_accum_ctrl)
//   master  the environment side (operand source, table, result sink)
// -----------------------------------------------------------------------------
interface xpb_accum_ctrl_if #(
    parameter int NUM_DIGITS = 8,
    parameter int DATA_W     = 1024
);
    localparam int SEL_W = $clog2(NUM_DIGITS);
    localparam int ACC_W = DATA_W + $clog2(NUM_DIGITS);

    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_DIGITS*5-1:0] in_digits;
    logic                    xpb_req;
    logic [SEL_W-1:0]        xpb_sel;
    logic [4:0]              xpb_digit;
    logic [DATA_W-1:0]       xpb_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [ACC_W-1:0]        out_sum;
    logic                    busy;

    modport slave (
        input  in_valid, in_digits, xpb_data, out_ready,
        output in_ready, xpb_req, xpb_sel, xpb_digit, out_valid, out_sum, busy
    );

    modport master (
        output in_valid, in_digits, xpb_data, out_ready,
        input  in_ready, xpb_req, xpb_sel, xpb_digit, out_valid, out_sum, busy
    );
endinterface

// File: rtl/xpb_accum_ctrl.sv
// -----------------------------------------------------------------------------
// xpb_accum_ctrl
//
// Sequences one xpb table lookup per digit of an operand and accumulates the
// returned table entries into a single wide sum.
//
// Ports:
//   clk     single clock, rising-edge
//   rst_n   asynchronous active-low reset
//   bus     xpb_accum_ctrl_if.slave: operand handshake, lookup bus, result
//
// Operation: IDLE accepts an operand, ISSUE emits one lookup per cycle in
// ascending digit order, DRAIN absorbs the last registered table output, DONE
// presents out_sum until the consumer takes it. With k issued digits and the
// accept in cycle T, out_valid first rises in cycle T+k+2.
//
// Build option:
//   XPB_ZERO_SKIP_EN  when defined, zero digits are not looked up (their table
//                     entry is zero); an all-zero operand goes straight to
//                     DRAIN. When undefined every digit is issued.
// -----------------------------------------------------------------------------
module xpb_accum_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int DATA_W     = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    xpb_accum_ctrl_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_DIGITS);
    localparam int ACC_W = DATA_W + SEL_W;
    localparam int DIG_W = NUM_DIGITS * 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_q;
    logic                  in_ready_q;
    logic                  xpb_req_q;
    logic [SEL_W-1:0]      xpb_sel_q;
    logic [4:0]            xpb_digit_q;
    logic                  out_valid_q;
    logic                  busy_q;
    logic                  data_vld_q;   // xpb_data carries an entry this cycle
    logic [NUM_DIGITS-1:0] pend_q;       // digits still waiting to be issued
    logic [ACC_W-1:0]      acc_q;
    logic [ACC_W-1:0]      out_sum_q;
    logic [DIG_W-1:0]      digits_q;

    logic [NUM_DIGITS-1:0] in_mask;
    logic [NUM_DIGITS-1:0] src_mask;
    logic [DIG_W-1:0]      src_digits;
    logic                  has_next;
    logic [SEL_W-1:0]      sel_d;
    logic [4:0]            digit_d;
    logic [NUM_DIGITS-1:0] pend_d;
    logic [ACC_W-1:0]      acc_d;

    // Index of the lowest set bit; the descending scan lets the lowest win.
    function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_DIGITS-1:0] m);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (m[i]) idx = SEL_W'(i);
        end
        return idx;
    endfunction

    always_comb begin
        in_mask = '0;
`ifdef XPB_ZERO_SKIP_EN
        for (int i = 0; i < NUM_DIGITS; i++) begin
            in_mask[i] = |bus.in_digits[5*i +: 5];
        end
`else
        in_mask = '1;
`endif
        // The first lookup is issued on the accept edge straight from the
        // operand bus; later ones come from the latched copy.
        src_mask   = (state_q == IDLE) ? in_mask : pend_q;
        src_digits = (state_q == IDLE) ? bus.in_digits : digits_q;
        has_next   = |src_mask;
        sel_d      = lowest_set(src_mask);
        digit_d    = src_digits[int'(sel_d)*5 +: 5];
        pend_d     = src_mask & ~(NUM_DIGITS'(1) << sel_d);
        acc_d      = acc_q + (data_vld_q ? {{SEL_W{1'b0}}, bus.xpb_data} : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            xpb_req_q   <= 1'b0;
            xpb_sel_q   <= '0;
            xpb_digit_q <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            data_vld_q  <= 1'b0;
            pend_q      <= '0;
            acc_q       <= '0;
            out_sum_q   <= '0;
        end else begin
            // Table output is registered: an entry arrives one cycle after its request.
            data_vld_q <= xpb_req_q;
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        acc_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (has_next) begin
                            state_q     <= ISSUE;
                            xpb_req_q   <= 1'b1;
                            xpb_sel_q   <= sel_d;
                            xpb_digit_q <= digit_d;
                            pend_q      <= pend_d;
                        end else begin
                            state_q <= DRAIN;
                            pend_q  <= '0;
                        end
                    end
                end
                ISSUE: begin
                    acc_q <= acc_d;
                    if (has_next) begin
                        xpb_req_q   <= 1'b1;
                        xpb_sel_q   <= sel_d;
                        xpb_digit_q <= digit_d;
                        pend_q      <= pend_d;
                    end else begin
                        state_q     <= DRAIN;
                        xpb_req_q   <= 1'b0;
                        xpb_sel_q   <= '0;
                        xpb_digit_q <= '0;
                    end
                end
                DRAIN: begin
                    // Last entry (if any) is on xpb_data now; fold it in and publish.
                    acc_q       <= acc_d;
                    out_sum_q   <= acc_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Operand copy carries data only; it is always reloaded before use.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && bus.in_valid) begin
            digits_q <= bus.in_digits;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.xpb_req   = xpb_req_q;
    assign bus.xpb_sel   = xpb_sel_q;
    assign bus.xpb_digit = xpb_digit_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_xpb_accum_ctrl.sv
`timescale 1ns/1ps
module tb_xpb_accum_ctrl;
    localparam int NUM_DIGITS = 8;
    localparam int DATA_W     = 1024;
    localparam int SEL_W      = 3;
    localparam int ACC_W      = 1027;
    localparam int DIG_W      = 40;
`ifdef XPB_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    xpb_accum_ctrl_if #(.NUM_DIGITS(NUM_DIGITS), .DATA_W(DATA_W)) bus ();

    xpb_accum_ctrl #(.NUM_DIGITS(NUM_DIGITS), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Table model: entry for digit 0 is zero; mode 0 returns all ones for any
    // nonzero digit, mode 1 returns sel*32+digit. Registered like the real table;
    // non-request cycles return junk so stray accumulation shows up.
    int tb_mode = 0;
    function automatic logic [DATA_W-1:0] model(input int mode, input logic [SEL_W-1:0] sel,
                                                input logic [4:0] dig);
        if (dig == 5'd0) return '0;
        if (mode == 0) return '1;
        return DATA_W'(int'(sel) * 32 + int'(dig));
    endfunction

    always @(posedge clk) begin
        bus.xpb_data <= bus.xpb_req ? model(tb_mode, bus.xpb_sel, bus.xpb_digit) : '1;
    end

    typedef struct {
        string            name;
        int               mode;
        logic [DIG_W-1:0] digits;
        int               exp_k;
        logic [ACC_W-1:0] exp_sum;
    } vec_t;

    vec_t vecs[6];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [ACC_W-1:0] act,
                         input logic [ACC_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one operand, follow it to DONE and check requests, latency and sum.
    task automatic op_until_done(input vec_t v);
        logic [SEL_W-1:0] exp_sel[$];
        logic [4:0]       exp_dig[$];
        logic [DIG_W-1:0] d;
        int  lat, nreq;
        bit  order_ok, idle_ok, seen;
        d = v.digits;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!SKIP || d[5*i +: 5] != 5'd0) begin
                exp_sel.push_back(SEL_W'(i));
                exp_dig.push_back(d[5*i +: 5]);
            end
        end
        check({v.name, ".in_ready_before"}, ACC_W'(bus.in_ready), 1);
        tb_mode       = v.mode;
        bus.in_digits = v.digits;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1; nreq = 0; order_ok = 1; idle_ok = 1; seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.out_valid) begin
                seen = 1;
                break;
            end
            if (bus.xpb_req) begin
                if (nreq >= exp_sel.size() || bus.xpb_sel != exp_sel[nreq] ||
                    bus.xpb_digit != exp_dig[nreq]) order_ok = 0;
                nreq++;
            end else if (bus.xpb_sel != '0 || bus.xpb_digit != '0) begin
                idle_ok = 0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        check({v.name, ".done_reached"}, ACC_W'(seen), 1);
        if (seen) begin
            check({v.name, ".latency"}, ACC_W'(lat), ACC_W'(v.exp_k + 2));
            check({v.name, ".req_count"}, ACC_W'(nreq), ACC_W'(v.exp_k));
            check({v.name, ".req_order"}, ACC_W'(order_ok), 1);
            check({v.name, ".idle_sel_zero"}, ACC_W'(idle_ok), 1);
            check({v.name, ".out_sum"}, bus.out_sum, v.exp_sum);
            check({v.name, ".in_ready_done"}, ACC_W'(bus.in_ready), 0);
            check({v.name, ".busy_done"}, ACC_W'(bus.busy), 1);
        end
    endtask

    task automatic out_handshake(input string name);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({name, ".out_valid_after_hs"}, ACC_W'(bus.out_valid), 0);
        check({name, ".in_ready_after_hs"}, ACC_W'(bus.in_ready), 1);
        check({name, ".busy_after_hs"}, ACC_W'(bus.busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        bus.in_valid  = 1'b0;
        bus.in_digits = '0;
        bus.out_ready = 1'b0;

        vecs[0] = '{"all_1f", 0, {8{5'h1F}}, 8, {{1024{1'b1}}, 3'b000}};
        vecs[1] = '{"ascending", 1, {5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, 8,
                    ACC_W'(32'h3A4)};
        vecs[2] = '{"digit3_only", 1, {5'd0, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd0},
                    (SKIP ? 1 : 8), ACC_W'(32'h67)};
        vecs[3] = '{"all_zero", 1, 40'd0, (SKIP ? 0 : 8), '0};
        vecs[4] = '{"mixed", 1, {5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd0, 5'd5},
                    (SKIP ? 3 : 8), ACC_W'(32'h145)};
        vecs[5] = '{"top_digit", 0, {5'h1F, 35'd0}, (SKIP ? 1 : 8),
                    {3'b000, {1024{1'b1}}}};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset.in_ready", ACC_W'(bus.in_ready), 1);
        check("reset.out_valid", ACC_W'(bus.out_valid), 0);
        check("reset.xpb_req", ACC_W'(bus.xpb_req), 0);
        check("reset.xpb_sel", ACC_W'(bus.xpb_sel), 0);
        check("reset.out_sum", bus.out_sum, '0);
        check("reset.busy", ACC_W'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven operations
        for (int i = 0; i < 6; i++) begin
            op_until_done(vecs[i]);
            out_handshake(vecs[i].name);
        end

        // Stall in DONE with in_valid pulses, then handshake and re-accept
        op_until_done(vecs[1]);
        for (int c = 0; c < 5; c++) begin
            bus.in_valid  = c[0] ? 1'b0 : 1'b1;
            bus.in_digits = vecs[2].digits;
            @(posedge clk);
            #1;
            check("stall.out_valid", ACC_W'(bus.out_valid), 1);
            check("stall.out_sum", bus.out_sum, vecs[1].exp_sum);
            check("stall.in_ready", ACC_W'(bus.in_ready), 0);
        end
        bus.in_valid  = 1'b1;
        bus.in_digits = vecs[1].digits;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("stall.no_accept_on_hs.busy", ACC_W'(bus.busy), 0);
        check("stall.no_accept_on_hs.in_ready", ACC_W'(bus.in_ready), 1);
        check("stall.no_accept_on_hs.xpb_req", ACC_W'(bus.xpb_req), 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("stall.accept_next.busy", ACC_W'(bus.busy), 1);
        check("stall.accept_next.xpb_req", ACC_W'(bus.xpb_req), 1);
        check("stall.accept_next.xpb_digit", ACC_W'(bus.xpb_digit), 1);
        found = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.out_valid) begin
                found = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("stall.second_done", ACC_W'(found), 1);
        check("stall.second_sum", bus.out_sum, ACC_W'(32'h3A4));
        out_handshake("stall.second");

        // Reset during the 4th issue
        tb_mode       = 1;
        bus.in_digits = vecs[1].digits;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        found = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.xpb_req && bus.xpb_sel == 3'd3) begin
                found = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("midreset.reached_4th_issue", ACC_W'(found), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset.xpb_req", ACC_W'(bus.xpb_req), 0);
        check("midreset.xpb_sel", ACC_W'(bus.xpb_sel), 0);
        check("midreset.in_ready", ACC_W'(bus.in_ready), 1);
        check("midreset.busy", ACC_W'(bus.busy), 0);
        check("midreset.out_sum", bus.out_sum, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        op_until_done(vecs[1]);
        out_handshake("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
